// File: rtl/fp_sub_seq_if.sv
// Handshake bundle for fp_sub_seq: operand channel (a, b) and result channel.
// The master drives operands and consumes results; the slave is the subtractor.
interface fp_sub_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE 754 single-precision subtractor (result = a - b), truncating.
// Optional FP_SUB_SPECIAL_EN resolves NaN/infinity operands early; without it exp 255 is finite.
module fp_sub_seq #(
   parameter int NORM_MAX = 24
) (
   input  logic         clk,
   input  logic         rst,
   fp_sub_seq_if.slave  bus
);
   localparam int CNT_W = $clog2(NORM_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NORM_MAX);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t           state;
   state_t           state_next;

   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic             sign_q;
   logic             eff_sub_q;
   logic [7:0]       exp_q;
   logic [23:0]      mant_l_q;
   logic [23:0]      mant_s_q;
   logic [23:0]      mant_q;
   logic [CNT_W-1:0] cnt_q;
   logic             spec_hit_q;
   logic [31:0]      spec_res_q;
   logic [31:0]      result_q;
   logic             out_valid_q;

   // Operand decode: b's sign is flipped so the rest is a signed-magnitude add.
   logic        sign_a;
   logic        sign_b;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic [23:0] mant_a;
   logic [23:0] mant_b;
   logic        a_larger;
   logic        l_sign;
   logic        s_sign;
   logic [7:0]  l_exp;
   logic [7:0]  s_exp;
   logic [23:0] l_mant;
   logic [23:0] s_mant;
   logic [7:0]  diff;
   logic [23:0] s_aligned;

   assign sign_a   = a_q[31];
   assign sign_b   = ~b_q[31];
   assign exp_a    = a_q[30:23];
   assign exp_b    = b_q[30:23];
   assign mant_a   = (exp_a == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
   assign mant_b   = (exp_b == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
   assign a_larger = {exp_a, mant_a} >= {exp_b, mant_b};

   assign l_sign    = a_larger ? sign_a : sign_b;
   assign s_sign    = a_larger ? sign_b : sign_a;
   assign l_exp     = a_larger ? exp_a  : exp_b;
   assign s_exp     = a_larger ? exp_b  : exp_a;
   assign l_mant    = a_larger ? mant_a : mant_b;
   assign s_mant    = a_larger ? mant_b : mant_a;
   assign diff      = l_exp - s_exp;
   assign s_aligned = (diff >= 8'd24) ? 24'd0 : (s_mant >> diff);

   logic        spec_hit;
   logic [31:0] spec_res;

`ifdef FP_SUB_SPECIAL_EN
   logic a_nan;
   logic b_nan;
   logic a_inf;
   logic b_inf;

   assign a_nan = (exp_a == 8'hFF) && (a_q[22:0] != 23'd0);
   assign b_nan = (exp_b == 8'hFF) && (b_q[22:0] != 23'd0);
   assign a_inf = (exp_a == 8'hFF) && (a_q[22:0] == 23'd0);
   assign b_inf = (exp_b == 8'hFF) && (b_q[22:0] == 23'd0);

   assign spec_hit = a_nan | b_nan | a_inf | b_inf;

   // Opposing infinities cancel to NaN; a lone infinity passes through with b negated.
   always_comb begin
      spec_res = 32'h7FC0_0000;
      if (a_nan || b_nan) begin
         spec_res = 32'h7FC0_0000;
      end else if (a_inf && b_inf) begin
         spec_res = (sign_a == sign_b) ? a_q : 32'h7FC0_0000;
      end else if (a_inf) begin
         spec_res = a_q;
      end else if (b_inf) begin
         spec_res = {sign_b, b_q[30:0]};
      end
   end
`else
   assign spec_hit = 1'b0;
   assign spec_res = 32'd0;
`endif

   logic [24:0] sum;
   logic [8:0]  exp_inc;
   logic        add_ovf;
   logic        add_to_done;

   assign sum         = eff_sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                                  : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
   assign exp_inc     = {1'b0, exp_q} + 9'd1;
   assign add_ovf     = sum[24] && (exp_inc == 9'd255);
   assign add_to_done = spec_hit_q || add_ovf;

   logic norm_zero;
   logic norm_packed;
   logic norm_flush;
   logic norm_done;

   assign norm_zero   = (mant_q == 24'd0);
   assign norm_packed = mant_q[23];
   assign norm_flush  = (exp_q == 8'd1) || (cnt_q == CNT_MAX);
   assign norm_done   = norm_zero || norm_packed || norm_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = ALIGN;
         ALIGN:   state_next = ADD;
         ADD:     state_next = add_to_done ? DONE : NORM;
         NORM:    if (norm_done) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers advance with the state; every terminal path loads result_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         sign_q      <= 1'b0;
         eff_sub_q   <= 1'b0;
         exp_q       <= 8'd0;
         mant_l_q    <= 24'd0;
         mant_s_q    <= 24'd0;
         mant_q      <= 24'd0;
         cnt_q       <= '0;
         spec_hit_q  <= 1'b0;
         spec_res_q  <= 32'd0;
         result_q    <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q <= bus.a;
                  b_q <= bus.b;
               end
            end
            ALIGN: begin
               sign_q     <= l_sign;
               eff_sub_q  <= (l_sign != s_sign);
               exp_q      <= l_exp;
               mant_l_q   <= l_mant;
               mant_s_q   <= s_aligned;
               cnt_q      <= '0;
               spec_hit_q <= spec_hit;
               spec_res_q <= spec_res;
            end
            ADD: begin
               if (spec_hit_q) begin
                  result_q    <= spec_res_q;
                  out_valid_q <= 1'b1;
               end else if (add_ovf) begin
                  result_q    <= {sign_q, 8'hFF, 23'd0};
                  out_valid_q <= 1'b1;
               end else if (sum[24]) begin
                  mant_q <= sum[24:1];
                  exp_q  <= exp_inc[7:0];
               end else begin
                  mant_q <= sum[23:0];
               end
            end
            NORM: begin
               if (norm_zero) begin
                  result_q    <= 32'd0;
                  out_valid_q <= 1'b1;
               end else if (norm_packed) begin
                  result_q    <= {sign_q, exp_q, mant_q[22:0]};
                  out_valid_q <= 1'b1;
               end else if (norm_flush) begin
                  result_q    <= 32'd0;
                  out_valid_q <= 1'b1;
               end else begin
                  mant_q <= {mant_q[22:0], 1'b0};
                  exp_q  <= exp_q - 8'd1;
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) out_valid_q <= 1'b0;
            end
            default: begin
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
endmodule
